// File: rtl/ldst_pkg.sv
// Shared widths, packet field offsets, size encodings, FSM states and byte-lane helpers
// for the lane LD/ST responder.
package ldst_pkg;

  localparam int LDST_ADDR_W  = 32;
  localparam int LDST_REG_W   = 7;
  localparam int LDST_DATA_W  = 32;
  localparam int LDST_SPACE_W = 2;
  localparam int LDST_SIZE_W  = 2;
  localparam int LDST_PKT_W   = LDST_ADDR_W + LDST_REG_W + LDST_DATA_W + LDST_SPACE_W + LDST_SIZE_W;

  // Packet is {addr, loadReg, storeData, space, size}, MSB first.
  localparam int LDST_SIZE_LSB  = 0;
  localparam int LDST_SPACE_LSB = LDST_SIZE_LSB + LDST_SIZE_W;
  localparam int LDST_DATA_LSB  = LDST_SPACE_LSB + LDST_SPACE_W;
  localparam int LDST_REG_LSB   = LDST_DATA_LSB + LDST_DATA_W;
  localparam int LDST_ADDR_LSB  = LDST_REG_LSB + LDST_REG_W;

  typedef enum logic [1:0] {
    LDST_WORD = 2'b00,
    LDST_HALF = 2'b01,
    LDST_BYTE = 2'b10,
    LDST_RSVD = 2'b11
  } ldstSize_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_WB   = 2'b11
  } ldstState_t;

  // Byte offset of the lowest enabled lane; half ignores addr[0], word ignores both bits.
  function automatic logic [1:0] ldstOffset(input ldstSize_t size, input logic [1:0] lo);
    case (size)
      LDST_HALF: ldstOffset = {lo[1], 1'b0};
      LDST_BYTE: ldstOffset = lo;
      default:   ldstOffset = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] ldstBe(input ldstSize_t size, input logic [1:0] lo);
    logic [3:0] mask;
    case (size)
      LDST_HALF: mask = 4'b0011;
      LDST_BYTE: mask = 4'b0001;
      default:   mask = 4'b1111;
    endcase
    ldstBe = mask << ldstOffset(size, lo);
  endfunction

  function automatic logic ldstMisaligned(input ldstSize_t size, input logic [1:0] lo);
    case (size)
      LDST_HALF: ldstMisaligned = lo[0];
      LDST_BYTE: ldstMisaligned = 1'b0;
      default:   ldstMisaligned = (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] ldstStoreFmt(input ldstSize_t size, input logic [31:0] data);
    case (size)
      LDST_HALF: ldstStoreFmt = {2{data[15:0]}};
      LDST_BYTE: ldstStoreFmt = {4{data[7:0]}};
      default:   ldstStoreFmt = data;
    endcase
  endfunction

  function automatic logic [31:0] ldstLoadFmt(input ldstSize_t size, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    case (size)
      LDST_HALF: ldstLoadFmt = {16'h0000, shifted[15:0]};
      LDST_BYTE: ldstLoadFmt = {24'h000000, shifted[7:0]};
      default:   ldstLoadFmt = shifted;
    endcase
  endfunction

endpackage

// File: rtl/ldst_resp_fifo.sv
// Generic sync FIFO, head visible combinationally the cycle after push; caller must not push when full.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ldst_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] headData
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr[AW-1:0]] <= pushData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + (AW+1)'(1);
      if (pop)  rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  assign empty    = (wrPtr == rdPtr);
  assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign headData = mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/ldst_lane_responder.sv
// Buffers lane LD/ST packets, issues one memory access at a time and returns formatted load writebacks;
// push->request 2 cycles, backpressure via ldstPacketReady_o when full. LDST_RESP_MISALIGN_TRAP_EN enables misalign trap.
module ldst_lane_responder
  import ldst_pkg::*;
#(
  parameter int ADDR_W     = LDST_ADDR_W,
  parameter int REG_W      = LDST_REG_W,
  parameter int DATA_W     = LDST_DATA_W,
  parameter int SPACE_W    = LDST_SPACE_W,
  parameter int SIZE_W     = LDST_SIZE_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          ldstPacketValid_i,
  input  logic [ADDR_W+REG_W+DATA_W+SPACE_W+SIZE_W-1:0] ldstPacket_i,
  input  logic                                          ldstIsStore_i,
  output logic                                          ldstPacketReady_o,
  output logic                                          memReqValid_o,
  input  logic                                          memReqReady_i,
  output logic                                          memReqWe_o,
  output logic [ADDR_W-1:0]                             memReqAddr_o,
  output logic [DATA_W-1:0]                             memReqWdata_o,
  output logic [3:0]                                    memReqBe_o,
  input  logic                                          memRespValid_i,
  input  logic [DATA_W-1:0]                             memRespData_i,
  output logic                                          wbValid_o,
  output logic [REG_W-1:0]                              wbReg_o,
  output logic [DATA_W-1:0]                             wbData_o,
  input  logic                                          wbReady_i,
  output logic                                          misalignErr_o
);

  localparam int PKT_W     = ADDR_W + REG_W + DATA_W + SPACE_W + SIZE_W;
  localparam int SIZE_LSB  = 0;
  localparam int SPACE_LSB = SIZE_LSB + SIZE_W;
  localparam int DATA_LSB  = SPACE_LSB + SPACE_W;
  localparam int REG_LSB   = DATA_LSB + DATA_W;
  localparam int ADDR_LSB  = REG_LSB + REG_W;

  logic             fifoPush;
  logic             fifoPop;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [PKT_W:0]   fifoHead;

  logic [ADDR_W-1:0] headAddr;
  logic [REG_W-1:0]  headReg;
  logic [DATA_W-1:0] headData;
  ldstSize_t         headSize;
  logic              headStore;
  logic              headMis;

  ldstState_t        state;
  ldstState_t        stateNxt;

  logic [ADDR_W-1:0] issAddr;
  logic [REG_W-1:0]  issReg;
  logic [DATA_W-1:0] issWdata;
  logic [3:0]        issBe;
  logic              issWe;
  ldstSize_t         issSize;
  logic [1:0]        issOff;
  logic [DATA_W-1:0] wbData;

  assign fifoPush          = ldstPacketValid_i & ~fifoFull;
  assign ldstPacketReady_o = ~fifoFull;

  ldst_resp_fifo #(
    .WIDTH (PKT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifoPush),
    .pushData ({ldstIsStore_i, ldstPacket_i}),
    .pop      (fifoPop),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .headData (fifoHead)
  );

  assign headAddr  = fifoHead[ADDR_LSB +: ADDR_W];
  assign headReg   = fifoHead[REG_LSB +: REG_W];
  assign headData  = fifoHead[DATA_LSB +: DATA_W];
  assign headSize  = ldstSize_t'(fifoHead[SIZE_LSB +: 2]);
  assign headStore = fifoHead[PKT_W];

  // Address space is global-only today; carried through the buffer but not decoded.
  logic unusedSpace;
  assign unusedSpace = ^fifoHead[SPACE_LSB +: SPACE_W];

`ifdef LDST_RESP_MISALIGN_TRAP_EN
  assign headMis = ldstMisaligned(headSize, headAddr[1:0]);
`else
  assign headMis = 1'b0;
`endif

  assign misalignErr_o = (state == ST_IDLE) & ~fifoEmpty & headMis;

  always_comb begin
    stateNxt = state;
    fifoPop  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifoEmpty) begin
          fifoPop = 1'b1;
          // A trapped load still returns a zero writeback so the register tag is retired.
          if (headMis) stateNxt = headStore ? ST_IDLE : ST_WB;
          else         stateNxt = ST_REQ;
        end
      end
      ST_REQ:  if (memReqReady_i)  stateNxt = issWe ? ST_IDLE : ST_RESP;
      ST_RESP: if (memRespValid_i) stateNxt = ST_WB;
      ST_WB:   if (wbReady_i)      stateNxt = ST_IDLE;
      default: stateNxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      issAddr  <= '0;
      issReg   <= '0;
      issWdata <= '0;
      issBe    <= '0;
      issWe    <= 1'b0;
      issSize  <= LDST_WORD;
      issOff   <= '0;
      wbData   <= '0;
    end else begin
      state <= stateNxt;
      if (fifoPop) begin
        issAddr  <= {headAddr[ADDR_W-1:2], 2'b00};
        issReg   <= headReg;
        issWdata <= ldstStoreFmt(headSize, headData);
        issBe    <= ldstBe(headSize, headAddr[1:0]);
        issWe    <= headStore;
        issSize  <= headSize;
        issOff   <= ldstOffset(headSize, headAddr[1:0]);
        wbData   <= '0;
      end
      if (state == ST_RESP && memRespValid_i)
        wbData <= ldstLoadFmt(issSize, issOff, memRespData_i);
    end
  end

  assign memReqValid_o = (state == ST_REQ);
  assign memReqWe_o    = issWe;
  assign memReqAddr_o  = issAddr;
  assign memReqWdata_o = issWdata;
  assign memReqBe_o    = issBe;

  assign wbValid_o = (state == ST_WB);
  assign wbReg_o   = issReg;
  assign wbData_o  = wbData;

endmodule
